// File: rtl/arc4_key_search.sv
// Key-search controller for the ARC4 decrypt core: steps candidate keys
// through the core's en/rdy handshake until one is accepted or the key space runs out.
module arc4_key_search #(
   parameter logic [23:0] KEY_FIRST  = 24'h000000,
   parameter logic [23:0] KEY_STRIDE = 24'd1,
   parameter logic [23:0] KEY_LAST   = 24'hFFFFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   output logic        rdy,
   output logic        key_valid,
   output logic [23:0] key_out,
   output logic [23:0] attempts,
   output logic        core_en,
   input  logic        core_rdy,
   output logic [23:0] core_key,
   input  logic        core_key_fail
);

   typedef enum logic [2:0] {
      IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, CHECK, FOUND, EXHAUST
   } state_t;

   state_t      state;
   logic [23:0] cand;
   logic        busy_hold;
   logic [24:0] next_cand;
   logic        last_cand;

   // Bit 24 of the sum flags a wrap past FFFFFF; the compare then also fails.
   assign next_cand = {1'b0, cand} + {1'b0, KEY_STRIDE};
   assign last_cand = (cand == KEY_LAST) || next_cand[24] || (next_cand > {1'b0, KEY_LAST});

   // NOTE: core_en is combinational so the start pulse lines up with the
   // exact cycle the core is ready; registering it would launch into a busy core.
   assign core_en  = (state == LAUNCH) && core_rdy;
   assign core_key = cand;

   // NOTE: every register here uses non-blocking assignment so all state
   // updates see the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         rdy       <= 1'b1;
         key_valid <= 1'b0;
         key_out   <= '0;
         attempts  <= '0;
         cand      <= KEY_FIRST;
         busy_hold <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (en) begin
                  rdy       <= 1'b0;
                  key_valid <= 1'b0;
                  key_out   <= '0;
                  attempts  <= '0;
                  cand      <= KEY_FIRST;
                  state     <= LAUNCH;
               end
            end
            LAUNCH: begin
               if (core_rdy) begin
                  if (attempts != '1) attempts <= attempts + 24'd1;
                  busy_hold <= 1'b0;
                  state     <= WAIT_BUSY;
               end
            end
            WAIT_BUSY: begin
               // A core that never drops rdy is treated as having finished instantly.
               if (!core_rdy)     state     <= WAIT_DONE;
               else if (busy_hold) state    <= CHECK;
               else               busy_hold <= 1'b1;
            end
            WAIT_DONE: begin
               if (core_rdy) state <= CHECK;
            end
            CHECK: begin
               if (!core_key_fail) begin
                  state <= FOUND;
               end else if (last_cand) begin
                  state <= EXHAUST;
               end else begin
                  cand  <= next_cand[23:0];
                  state <= LAUNCH;
               end
            end
            FOUND: begin
               key_out   <= cand;
               key_valid <= 1'b1;
               rdy       <= 1'b1;
               state     <= IDLE;
            end
            EXHAUST: begin
               key_out   <= '0;
               key_valid <= 1'b0;
               rdy       <= 1'b1;
               state     <= IDLE;
            end
            default: begin
               rdy   <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_arc4_key_search.sv
// Bench for arc4_key_search: four parameterisations, each paired with a
// behavioural ARC4 core model that passes a single chosen key.
module tb_arc4_key_search;

   localparam int NI        = 4;
   localparam int CORE_BUSY = 5;

   function automatic logic [23:0] first_of(input int i);
      case (i)
         1:       return 24'h000001;
         2:       return 24'hFFFFFE;
         3:       return 24'h000005;
         default: return 24'h000000;
      endcase
   endfunction

   function automatic logic [23:0] stride_of(input int i);
      return (i == 1) ? 24'd2 : 24'd1;
   endfunction

   function automatic logic [23:0] last_of(input int i);
      case (i)
         1:       return 24'h00000F;
         3:       return 24'h000003;
         default: return 24'hFFFFFF;
      endcase
   endfunction

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [NI-1:0] en = '0;
   logic [NI-1:0] rdy, key_valid, core_en;
   logic [NI-1:0] core_rdy  = '1;
   logic [NI-1:0] core_fail = '1;
   logic [23:0] key_out [NI];
   logic [23:0] attempts [NI];
   logic [23:0] core_key [NI];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      arc4_key_search #(
         .KEY_FIRST (first_of(g)),
         .KEY_STRIDE(stride_of(g)),
         .KEY_LAST  (last_of(g))
      ) dut (
         .clk          (clk),
         .rst_n        (rst_n),
         .en           (en[g]),
         .rdy          (rdy[g]),
         .key_valid    (key_valid[g]),
         .key_out      (key_out[g]),
         .attempts     (attempts[g]),
         .core_en      (core_en[g]),
         .core_rdy     (core_rdy[g]),
         .core_key     (core_key[g]),
         .core_key_fail(core_fail[g])
      );
   end

   // Core model: accepts on en&&rdy, stays busy CORE_BUSY cycles, then
   // reports fail unless the launched key equals pass_key. Ignores rst_n.
   int          cyc = 0;
   int          busy [NI];
   int          n_launch [NI];
   int          stall_until [NI];
   logic [23:0] pass_key [NI];
   logic [23:0] run_key [NI];
   logic [23:0] key_log [NI][64];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < NI; i++) begin
         if (core_en[i] && core_rdy[i]) begin
            key_log[i][n_launch[i] % 64] <= core_key[i];
            n_launch[i] <= n_launch[i] + 1;
            run_key[i]  <= core_key[i];
            busy[i]     <= CORE_BUSY;
            core_rdy[i] <= 1'b0;
         end else if (busy[i] > 1) begin
            busy[i] <= busy[i] - 1;
         end else if (busy[i] == 1) begin
            busy[i]      <= 0;
            core_rdy[i]  <= 1'b1;
            core_fail[i] <= (run_key[i] != pass_key[i]);
         end else begin
            core_rdy[i] <= (cyc >= stall_until[i]);
         end
      end
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: walk the candidate sequence with plain integer arithmetic.
   logic [23:0] exp_keys [$];

   task automatic ref_search(input int i, input logic [23:0] pass,
                             output logic v, output logic [23:0] key, output int n);
      longint k = longint'(first_of(i));
      exp_keys.delete();
      v   = 1'b0;
      key = '0;
      while (1) begin
         exp_keys.push_back(k[23:0]);
         if (k[23:0] == pass) begin
            v   = 1'b1;
            key = pass;
            break;
         end
         if (k == longint'(last_of(i)) || k + longint'(stride_of(i)) > longint'(last_of(i))
             || exp_keys.size() >= 64) break;
         k += longint'(stride_of(i));
      end
      n = exp_keys.size();
   endtask

   task automatic wait_rdy(input int i, input string tag);
      for (int c = 0; c < 3000 && !rdy[i]; c++) @(negedge clk);
      check({tag, "_done"}, 32'(rdy[i]), 32'd1);
   endtask

   task automatic run_search(input int i, input string tag);
      wait_rdy(i, {tag, "_idle"});
      en[i] = 1'b1;
      @(negedge clk);
      en[i] = 1'b0;
      check({tag, "_busy"}, 32'(rdy[i]), 32'd0);
      wait_rdy(i, tag);
   endtask

   task automatic verify(input int i, input logic [23:0] pass, input bit use_exp,
                         input logic ev, input logic [23:0] ek, input int ea, input string tag);
      logic        mv;
      logic [23:0] mk;
      int          mn, base;
      pass_key[i] = pass;
      base = n_launch[i];
      run_search(i, tag);
      ref_search(i, pass, mv, mk, mn);
      if (use_exp) begin
         mv = ev;
         mk = ek;
         mn = ea;
      end
      check({tag, "_valid"},    32'(key_valid[i]),      32'(mv));
      check({tag, "_key"},      32'(key_out[i]),        32'(mk));
      check({tag, "_attempts"}, 32'(attempts[i]),       32'(mn));
      check({tag, "_launches"}, 32'(n_launch[i] - base), 32'(exp_keys.size()));
      for (int j = 0; j < exp_keys.size() && j < n_launch[i] - base; j++)
         check($sformatf("%s_k%0d", tag, j), 32'(key_log[i][(base + j) % 64]), 32'(exp_keys[j]));
   endtask

   typedef struct {
      int          inst;
      logic [23:0] pass;
      logic        exp_valid;
      logic [23:0] exp_key;
      int          exp_attempts;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int          base, viol, inst;
      logic [23:0] pass;

      vecs[0] = '{0, 24'h00000A, 1'b1, 24'h00000A, 11};
      vecs[1] = '{1, 24'h000006, 1'b0, 24'h000000, 8};
      vecs[2] = '{2, 24'h000000, 1'b0, 24'h000000, 2};
      vecs[3] = '{3, 24'h000005, 1'b1, 24'h000005, 1};
      vecs[4] = '{3, 24'h000004, 1'b0, 24'h000000, 1};
      vecs[5] = '{0, 24'h000000, 1'b1, 24'h000000, 1};
      for (int i = 0; i < NI; i++) pass_key[i] = 24'h000000;

      repeat (3) @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         check($sformatf("rst_rdy%0d", i),      32'(rdy[i]),       32'd1);
         check($sformatf("rst_valid%0d", i),    32'(key_valid[i]), 32'd0);
         check($sformatf("rst_key%0d", i),      32'(key_out[i]),   32'd0);
         check($sformatf("rst_attempts%0d", i), 32'(attempts[i]),  32'd0);
         check($sformatf("rst_core_en%0d", i),  32'(core_en[i]),   32'd0);
         check($sformatf("rst_core_key%0d", i), 32'(core_key[i]),  32'(first_of(i)));
      end
      rst_n = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 6; v++)
         verify(vecs[v].inst, vecs[v].pass, 1'b1, vecs[v].exp_valid, vecs[v].exp_key,
                vecs[v].exp_attempts, $sformatf("vec%0d", v));

      // Core busy for 20 cycles before the first launch.
      pass_key[0]    = 24'h000000;
      base           = n_launch[0];
      stall_until[0] = cyc + 20;
      en[0]          = 1'b1;
      @(negedge clk);
      en[0] = 1'b0;
      viol  = 0;
      repeat (18) begin
         if (core_en[0] !== 1'b0 || core_rdy[0] !== 1'b0 || core_key[0] !== 24'h0) viol++;
         @(negedge clk);
      end
      check("stall_quiet", 32'(viol), 32'd0);
      wait_rdy(0, "stall");
      check("stall_launches", 32'(n_launch[0] - base), 32'd1);
      check("stall_attempts", 32'(attempts[0]),        32'd1);
      check("stall_valid",    32'(key_valid[0]),       32'd1);

      // Reset during WAIT_DONE of the third attempt.
      pass_key[0] = 24'h000020;
      base  = n_launch[0];
      en[0] = 1'b1;
      @(negedge clk);
      en[0] = 1'b0;
      for (int c = 0; c < 200 && n_launch[0] < base + 3; c++) @(negedge clk);
      check("abort_reached", 32'(n_launch[0] - base), 32'd3);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort_rdy",      32'(rdy[0]),       32'd1);
      check("abort_valid",    32'(key_valid[0]), 32'd0);
      check("abort_attempts", 32'(attempts[0]),  32'd0);
      check("abort_core_en",  32'(core_en[0]),   32'd0);
      verify(0, 24'h000001, 1'b1, 1'b1, 24'h000001, 2, "restart");

      // en held high: back-to-back searches, en ignored while busy.
      pass_key[0] = 24'h000002;
      base  = n_launch[0];
      en[0] = 1'b1;
      @(negedge clk);
      wait_rdy(0, "held1");
      check("held1_key",      32'(key_out[0]),   32'h2);
      check("held1_valid",    32'(key_valid[0]), 32'd1);
      check("held1_attempts", 32'(attempts[0]),  32'd3);
      @(negedge clk);
      check("held2_rdy",   32'(rdy[0]),       32'd0);
      check("held2_valid", 32'(key_valid[0]), 32'd0);
      en[0] = 1'b0;
      wait_rdy(0, "held2");
      check("held2_key",      32'(key_out[0]),          32'h2);
      check("held2_attempts", 32'(attempts[0]),         32'd3);
      check("held_launches",  32'(n_launch[0] - base),  32'd6);

      // Randomised pass keys against the reference walk.
      for (int r = 0; r < 10; r++) begin
         case ($urandom_range(0, 2))
            0: begin inst = 0; pass = 24'($urandom_range(0, 14)); end
            1: begin inst = 1; pass = 24'($urandom_range(0, 20)); end
            default: begin inst = 3; pass = 24'($urandom_range(2, 7)); end
         endcase
         verify(inst, pass, 1'b0, 1'b0, 24'h0, 0, $sformatf("rnd%0d_i%0d", r, inst));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
